spi_tx_arbiter: RTL

Round-robin arbiter sharing the single 24-bit transmit port of `spi_slave` (`wr_en`/`wr_data`/`wr_buffer_free`) between up to NREQ requesters, e.g. register readback, LED readback and vector streaming. A requester owns the port for a whole burst, terminated by its `last` flag, so multi-word replies such as 4-word vectors are never interleaved. It sits between the command handlers in `top` and `spi_slave`.

---
 rtl/spi_tx_arbiter_pkg.sv | 21 ++
 rtl/spi_tx_arbiter_if.sv | 29 ++
 rtl/spi_tx_arbiter_rr_pick.sv | 36 +++
 rtl/spi_tx_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/spi_tx_arbiter_pkg.sv
// Shared types and defaults for the SPI transmit arbiter and its picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_tx_arbiter_pkg;

   localparam int NREQ_DEF    = 4;
   localparam int DATA_W_DEF  = 24;
   localparam int TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Index of the requester after idx, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Bundle of requester-side and spi_slave-side signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: spi_wr_buffer_free gates the arbiter's write strobe.
// master: requesters plus spi_slave model; slave: the arbiter.
interface spi_tx_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 24
) ();
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        ack;
   logic [NREQ-1:0]        grant;
   logic                   busy;
   logic                   spi_wr_buffer_free;
   logic                   spi_wr_en;
   logic [DATA_W-1:0]      spi_wr_data;
   logic                   timeout_err;

   modport master (
      output req, req_data, req_last, spi_wr_buffer_free,
      input  ack, grant, busy, spi_wr_en, spi_wr_data, timeout_err
   );

   modport slave (
      input  req, req_data, req_last, spi_wr_buffer_free,
      output ack, grant, busy, spi_wr_en, spi_wr_data, timeout_err
   );
endinterface

// File: rtl/spi_tx_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; vld low when no request is pending.
// Ports: req (N), ptr (start index) -> grant (one-hot), idx, vld.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 vld
);
   localparam int PW = $clog2(N);

   int            j;
   logic [PW-1:0] jj;

   always_comb begin
      grant = '0;
      idx   = '0;
      vld   = 1'b0;
      j     = 0;
      jj    = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         jj = PW'(j);
         if (!vld && req[jj]) begin
            vld       = 1'b1;
            idx       = jj;
            grant[jj] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin, burst-locked arbiter for the single spi_slave transmit port.
// Latency: req in IDLE -> spi_wr_en 2 cycles; at most one word per 2 cycles.
// Backpressure: words wait in SEND while spi_wr_buffer_free is low; req held until ack.
// Ports: clk, reset (sync, active-high), bus (spi_tx_arbiter_if.slave).
// Optional macro SPI_TX_ARBITER_TIMEOUT_EN: revoke a grant stalled for TIMEOUT cycles.
module spi_tx_arbiter
   import spi_tx_arbiter_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic             clk,
   input logic             reset,
   spi_tx_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);

   state_e            state_q, state_d;
   logic [PW-1:0]     owner_q, rr_ptr_q, win_idx;
   logic [NREQ-1:0]   win_oh, grant_q, ack_q;
   logic              win_vld, last_q, busy_q, wr_en_q, owner_req;
   logic [DATA_W-1:0] wr_data_q;
   logic              do_grant, do_send, do_release, stall_hit;

   rr_pick #(.N(NREQ)) u_pick (
      .req   (bus.req),
      .ptr   (rr_ptr_q),
      .grant (win_oh),
      .idx   (win_idx),
      .vld   (win_vld)
   );

   assign owner_req = bus.req[owner_q];

`ifdef SPI_TX_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] stall_cnt_q;
   logic          err_q;

   // Fires on the TIMEOUT-th consecutive SEND cycle with the owner's req low.
   assign stall_hit = (state_q == ST_SEND) && !owner_req &&
                      (stall_cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         if (state_q == ST_SEND && !owner_req)
            stall_cnt_q <= stall_hit ? '0 : stall_cnt_q + 1'b1;
         else
            stall_cnt_q <= '0;
         if (stall_hit) err_q <= 1'b1;
      end
   end

   assign bus.timeout_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout  = (TIMEOUT > 0);
   assign stall_hit       = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (win_vld) state_d = ST_SEND;
         ST_SEND: begin
            if (owner_req && bus.spi_wr_buffer_free) state_d = ST_HOLD;
            else if (stall_hit)                      state_d = ST_IDLE;
         end
         // HOLD ignores free/req: both still reflect the word just written.
         ST_HOLD: state_d = last_q ? ST_IDLE : ST_SEND;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/control decode
   always_comb begin
      do_grant   = (state_q == ST_IDLE) && win_vld;
      do_send    = (state_q == ST_SEND) && owner_req && bus.spi_wr_buffer_free;
      do_release = ((state_q == ST_HOLD) && last_q) || stall_hit;
   end

   // Registered outputs; reset wins, so a strobe on the reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q   <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         busy_q    <= 1'b0;
         last_q    <= 1'b0;
         ack_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         ack_q   <= '0;
         wr_en_q <= 1'b0;
         if (do_grant) begin
            grant_q <= win_oh;
            owner_q <= win_idx;
            busy_q  <= 1'b1;
         end
         if (do_send) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= bus.req_data[owner_q*DATA_W +: DATA_W];
            ack_q     <= grant_q;
            last_q    <= bus.req_last[owner_q];
         end
         if (do_release) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= PW'(wrap_inc(int'(owner_q), NREQ));
         end
      end
   end

   assign bus.grant       = grant_q;
   assign bus.busy        = busy_q;
   assign bus.ack         = ack_q;
   assign bus.spi_wr_en   = wr_en_q;
   assign bus.spi_wr_data = wr_data_q;
endmodule
